// File: rtl/comma_aligner.sv
// Purpose: hunts for the K28.5 comma in the recovered bit stream and emits 10-bit words on the locked boundary.
// Latency: a word whose last bit is sampled at edge N is strobed on word_valid after edge N+1.
// Backpressure: none. The stream is free-running, and the downstream decoder must take every strobe.
module comma_aligner #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Din,
  output logic [9:0] word_out,
  output logic       word_valid,
  output logic       word_is_comma,
  output logic       locked,
  output logic       realign
);

  localparam logic [9:0] K28P5_RDN = 10'h17C;
  localparam logic [9:0] K28P5_RDP = 10'h283;
  localparam logic [3:0] LOCK_TH   = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TH   = 4'(LOSS_CNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t     state;
  logic [9:0] sr;
  logic [3:0] cnt;
  logic [3:0] good;
  logic [3:0] bad;
  logic       match;
  logic       boundary;
  logic [3:0] good_inc;
  logic [3:0] bad_inc;
  logic [3:0] cnt_nxt;

  // A full 10-bit compare against both disparities. sr = 0 never matches.
  assign match    = (sr == K28P5_RDN) || (sr == K28P5_RDP);
  assign boundary = (cnt == 4'd9);
  assign good_inc = (good == 4'hF) ? 4'hF : good + 4'd1;
  assign bad_inc  = (bad  == 4'hF) ? 4'hF : bad  + 4'd1;
  assign cnt_nxt  = boundary ? 4'd0 : cnt + 4'd1;

  // Serial bits enter at the top, so sr[0] is always the oldest bit (a).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {Din, sr[9:1]};
    end
  end

  // Alignment FSM. It owns the phase counter, the good/bad counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_HUNT;
      cnt           <= '0;
      good          <= '0;
      bad           <= '0;
      word_out      <= '0;
      word_valid    <= 1'b0;
      word_is_comma <= 1'b0;
      locked        <= 1'b0;
      realign       <= 1'b0;
    end else begin
      word_valid    <= 1'b0;
      word_is_comma <= 1'b0;
      realign       <= 1'b0;
      cnt           <= cnt_nxt;
      case (state)
        ST_HUNT: begin
          cnt <= 4'd0;
          if (match) begin
            realign       <= 1'b1;
            word_valid    <= 1'b1;
            word_is_comma <= 1'b1;
            word_out      <= sr;
            good          <= 4'd1;
            bad           <= 4'd0;
            state         <= ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (boundary) begin
            word_valid    <= 1'b1;
            word_is_comma <= match;
            word_out      <= sr;
            if (match) begin
              good <= good_inc;
              if (good_inc >= LOCK_TH) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
              end
            end
          end else if (match) begin
            // The comma arrived off the boundary, so the boundary moves to this comma.
            cnt           <= 4'd0;
            realign       <= 1'b1;
            word_valid    <= 1'b1;
            word_is_comma <= 1'b1;
            word_out      <= sr;
            good          <= 4'd1;
          end
        end
        ST_LOCKED: begin
          if (boundary) begin
            word_valid    <= 1'b1;
            word_is_comma <= match;
            word_out      <= sr;
            if (match) begin
              bad  <= 4'd0;
              good <= good_inc;
            end
          end else if (match) begin
            // The phase stays put. A misaligned comma is only counted.
            bad <= bad_inc;
            if (bad_inc >= LOSS_TH) begin
              locked <= 1'b0;
              good   <= 4'd0;
              bad    <= 4'd0;
              cnt    <= 4'd0;
              state  <= ST_HUNT;
            end
          end
        end
        default: begin
          state  <= ST_HUNT;
          locked <= 1'b0;
          cnt    <= 4'd0;
        end
      endcase
    end
  end

endmodule
